// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer between a valid/ready producer and
// consumer. A main entry drives the downstream side; a skid entry absorbs the
// one beat that can arrive while the consumer is not taking data. in_ready is
// derived from registered occupancy only, so no combinational path exists from
// out_ready or stall_i back to the upstream side.
//
// Parameters
//   DATA_W      payload width in bits (1..1024)
//   FLUSH_ZERO  1: flush also clears stored payloads, 0: flush drops valids only
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   flush_i    drop all held entries and the concurrent upstream beat
//   stall_i    freeze the downstream side (no pop while high)
//   in_valid   upstream beat valid
//   in_ready   stage can accept an upstream beat
//   in_data    upstream payload
//   out_valid  downstream beat valid
//   out_ready  downstream accepts the beat
//   out_data   downstream payload (main entry)
//   occ_o      number of entries held (0, 1, 2)
module pipe_skid_stage #(
    parameter int DATA_W     = 64,
    parameter int FLUSH_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;

    logic push;
    logic pop;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign occ_o     = state;

    // Flush suppresses both transfers so a flushed cycle never moves data.
    assign push = in_valid & in_ready & ~flush_i;
    assign pop  = out_valid & out_ready & ~stall_i & ~flush_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_i) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_next   = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_next = FULL;
                        load_skid  = 1'b1;
                    end else if (pop && !push) begin
                        state_next = EMPTY;
                    end else if (push && pop) begin
                        load_main_in = 1'b1;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        state_next     = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // Payload registers only change on a real load, reset or zeroing flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_data <= '0;
            skid_data <= '0;
        end else if (flush_i) begin
            if (FLUSH_ZERO != 0) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Testbench for pipe_skid_stage. Four instances share the control inputs:
// DATA_W 64 / 1 / 128 with zeroing flush, and DATA_W 64 with valid-only flush.
// A queue-based reference model predicts every output after each clock edge.
module tb_pipe_skid_stage;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush_i;
    logic         stall_i;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_data;

    logic         in_ready_a, out_valid_a;
    logic [63:0]  out_data_a;
    logic [1:0]   occ_a;
    logic         in_ready_b, out_valid_b;
    logic [0:0]   out_data_b;
    logic [1:0]   occ_b;
    logic         in_ready_c, out_valid_c;
    logic [127:0] out_data_c;
    logic [1:0]   occ_c;
    logic         in_ready_d, out_valid_d;
    logic [63:0]  out_data_d;
    logic [1:0]   occ_d;

    int checks = 0;
    int errors = 0;

    // Reference model state: beats held in order, plus what the main payload
    // register shows (it keeps its last value once the stage empties).
    logic [127:0] model_q[$];
    logic [127:0] main_z;
    logic [127:0] main_nz;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(64), .FLUSH_ZERO(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .stall_i(stall_i),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data[63:0]),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .occ_o(occ_a));

    pipe_skid_stage #(.DATA_W(1), .FLUSH_ZERO(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .stall_i(stall_i),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data[0:0]),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .occ_o(occ_b));

    pipe_skid_stage #(.DATA_W(128), .FLUSH_ZERO(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .stall_i(stall_i),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .occ_o(occ_c));

    pipe_skid_stage #(.DATA_W(64), .FLUSH_ZERO(0)) dut_d (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .stall_i(stall_i),
        .in_valid(in_valid), .in_ready(in_ready_d), .in_data(in_data[63:0]),
        .out_valid(out_valid_d), .out_ready(out_ready), .out_data(out_data_d),
        .occ_o(occ_d));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit do_push;
        bit do_pop;
        if (!rst_n) begin
            model_q.delete();
            main_z  = '0;
            main_nz = '0;
        end else if (flush_i) begin
            model_q.delete();
            main_z = '0;
        end else begin
            do_push = in_valid && (model_q.size() < 2);
            do_pop  = (model_q.size() > 0) && out_ready && !stall_i;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(in_data);
            if (model_q.size() > 0) begin
                main_z  = model_q[0];
                main_nz = model_q[0];
            end
        end
    endtask

    task automatic compare_all();
        logic         e_vld;
        logic         e_rdy;
        logic [1:0]   e_occ;
        e_vld = (model_q.size() > 0);
        e_rdy = (model_q.size() < 2);
        e_occ = 2'(model_q.size());
        chk("a.vld",  {127'b0, out_valid_a}, {127'b0, e_vld});
        chk("a.rdy",  {127'b0, in_ready_a},  {127'b0, e_rdy});
        chk("a.occ",  {126'b0, occ_a},       {126'b0, e_occ});
        chk("a.data", {64'b0, out_data_a},   {64'b0, main_z[63:0]});
        chk("b.vld",  {127'b0, out_valid_b}, {127'b0, e_vld});
        chk("b.occ",  {126'b0, occ_b},       {126'b0, e_occ});
        chk("b.rdy",  {127'b0, in_ready_b},  {127'b0, e_rdy});
        chk("b.data", {127'b0, out_data_b},  {127'b0, main_z[0]});
        chk("c.vld",  {127'b0, out_valid_c}, {127'b0, e_vld});
        chk("c.occ",  {126'b0, occ_c},       {126'b0, e_occ});
        chk("c.rdy",  {127'b0, in_ready_c},  {127'b0, e_rdy});
        chk("c.data", out_data_c,            main_z);
        chk("d.vld",  {127'b0, out_valid_d}, {127'b0, e_vld});
        chk("d.occ",  {126'b0, occ_d},       {126'b0, e_occ});
        chk("d.rdy",  {127'b0, in_ready_d},  {127'b0, e_rdy});
        chk("d.data", {64'b0, out_data_d},   {64'b0, main_nz[63:0]});
    endtask

    // Drive one cycle of inputs, clock, then check 1 time unit after the edge.
    task automatic cycle(input logic v, input logic [127:0] d, input logic ordy,
                         input logic st, input logic fl, input logic rn);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        stall_i   = st;
        flush_i   = fl;
        rst_n     = rn;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        logic [127:0] rd;
        main_z  = '0;
        main_nz = '0;
        in_valid = 0; in_data = '0; out_ready = 0; stall_i = 0; flush_i = 0; rst_n = 0;
        #1;

        // Reset state
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("rst.rdy", {127'b0, in_ready_a}, 128'd1);

        // Single beat with out_ready high
        cycle(1, 128'hA5, 1, 0, 0, 1);
        chk("one.data", {64'b0, out_data_a}, 128'hA5);
        chk("one.occ",  {126'b0, occ_a},     128'd1);
        cycle(0, 0, 1, 0, 0, 1);

        // Fill with downstream blocked, then drain
        cycle(1, 128'h11, 0, 0, 0, 1);
        cycle(1, 128'h22, 0, 0, 0, 1);
        chk("full.occ",  {126'b0, occ_a},      128'd2);
        chk("full.rdy",  {127'b0, in_ready_a}, 128'd0);
        chk("full.data", {64'b0, out_data_a},  128'h11);
        cycle(0, 0, 1, 0, 0, 1);
        chk("drain1.data", {64'b0, out_data_a}, 128'h22);
        cycle(0, 0, 1, 0, 0, 1);
        chk("drain2.occ", {126'b0, occ_a}, 128'd0);

        // Streaming at one beat per cycle
        for (int i = 0; i < 16; i++) begin
            cycle(1, 128'(i), 1, 0, 0, 1);
            chk("stream.data", {64'b0, out_data_a}, 128'(i));
        end
        cycle(0, 0, 1, 0, 0, 1);

        // Stall holds a full stage
        cycle(1, 128'h33, 0, 0, 0, 1);
        cycle(1, 128'h44, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 1, 0, 1);
            chk("stall.data", {64'b0, out_data_a}, 128'h33);
        end
        cycle(0, 0, 1, 0, 0, 1);
        chk("unstall.data", {64'b0, out_data_a}, 128'h44);
        cycle(0, 0, 1, 0, 0, 1);

        // Flush while full with a concurrent upstream beat
        cycle(1, 128'h66, 0, 0, 0, 1);
        cycle(1, 128'h77, 0, 0, 0, 1);
        cycle(1, 128'h55, 1, 0, 1, 1);
        chk("flush.data",  {64'b0, out_data_a}, 128'h0);
        chk("flush.dkeep", {64'b0, out_data_d}, 128'h66);
        cycle(0, 0, 1, 0, 0, 1);
        chk("flush.vld", {127'b0, out_valid_a}, 128'd0);

        // Reset while full, all widths
        rd = {$urandom, $urandom, $urandom, $urandom};
        cycle(1, rd, 0, 0, 0, 1);
        cycle(1, ~rd, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("rstfull.c", out_data_c, 128'h0);
        cycle(0, 0, 1, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            cycle(1'($urandom_range(0, 3) != 0), rd,
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 59) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter: DATA_W, default 64, payload width in bits (legal 1..1024).
REQ-002 Parameter: FLUSH_ZERO, default 1; 1 = flush zeroes stored payloads, 0 = flush clears valid bits only.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush_i  input  1  discard all held entries and the current upstream beat.
REQ-006 stall_i  input  1  freeze downstream side; no downstream transfer while high.
REQ-007 in_valid  input  1  upstream beat valid.
REQ-008 in_ready  output  1  stage can accept an upstream beat.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  downstream beat valid.
REQ-011 out_ready  input  1  downstream accepts beat.
REQ-012 out_data  output  DATA_W  downstream payload.
REQ-013 occ_o  output  2  entries held (0, 1 or 2).

Function
REQ-014 Storage: main entry (drives out_data/out_valid) plus one skid entry; states EMPTY (occ 0), ONE (main valid), FULL (main+skid valid).
REQ-015 in_ready = 1 in EMPTY and ONE, 0 in FULL; derived from registered state only, no combinational path from out_ready or stall_i.
REQ-016 Upstream transfer (push) = in_valid & in_ready & !flush_i; downstream transfer (pop) = out_valid & out_ready & !stall_i & !flush_i.
REQ-017 out_valid = 1 exactly in ONE and FULL; out_data = main payload.
REQ-018 EMPTY: push -> ONE, main <= in_data; else stay.
REQ-019 ONE: push & !pop -> FULL, skid <= in_data; pop & !push -> EMPTY; push & pop -> ONE, main <= in_data; neither -> stay.
REQ-020 FULL: pop -> ONE, main <= skid; else stay (push impossible, in_ready = 0).
REQ-021 Latency: beat pushed in cycle N is presented on out_valid in cycle N+1 when stage was EMPTY or popped in cycle N.
REQ-022 Order preserved: beats leave in push order; no beat duplicated or dropped except by flush.
REQ-023 Throughput: one beat per cycle sustained when out_ready = 1 and stall_i = 0.
REQ-024 stall_i high: no pop; main/skid payloads and out_valid held stable; push still allowed until FULL.
REQ-025 flush_i high: next state EMPTY regardless of other inputs; in_valid beat in same cycle dropped; if FLUSH_ZERO = 1 main and skid payloads <= 0.
REQ-026 Priority: rst_n low > flush_i > stall_i > normal handshake.
REQ-027 occ_o = registered state encoding (EMPTY 0, ONE 1, FULL 2); value 3 never produced.
REQ-028 Payload registers not written when no push/shift occurs (hold, no spurious toggle).

Reset
REQ-029 rst_n low at a rising edge: state EMPTY, out_valid 0, occ_o 0, out_data 0, skid payload 0; in_ready 1 from the first cycle after reset.
REQ-030 Reset mid-operation (ONE or FULL) discards all entries identically to REQ-029; no beat emitted after release until a new push.

Verification
REQ-031 Reset, then push 0xA5 with out_ready=1 -> out_valid=1, out_data=0xA5 next cycle, occ_o=1.
REQ-032 out_ready=0, push 0x11 then 0x22 -> occ_o=2, in_ready=0, out_data=0x11; raise out_ready -> 0x11 then 0x22 on consecutive cycles, occ_o 2->1->0.
REQ-033 Stream 0..15 with in_valid=1, out_ready=1 -> 16 beats out in order, one per cycle, in_ready never low.
REQ-034 FULL (0x33, 0x44), stall_i=1 with out_ready=1 for 3 cycles -> out_data stays 0x33, occ_o=2; drop stall_i -> 0x33 then 0x44.
REQ-035 FULL plus flush_i=1 with in_valid=1, in_data=0x55 -> next cycle out_valid=0, occ_o=0, in_ready=1, out_data=0 (FLUSH_ZERO=1); 0x55 never appears.
REQ-036 rst_n=0 while FULL and flush_i=0 -> next cycle occ_o=0, out_valid=0, out_data=0; repeat with DATA_W=1 and DATA_W=128.
